// File: rtl/array_xfer_pkg.sv
// Shared types for the array transfer sequencer.
// State encoding and transfer mode codes.
package array_xfer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        FILL,
        DRAIN,
        DONE
    } xfer_state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/xfer_idx_cnt.sv
// Element index counter for the transfer sequencer.
// Clears to 0, steps by one, saturates at DEPTH-1.
module xfer_idx_cnt #(
    parameter int DEPTH = 3,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    assign last = (idx == IDX_W'(DEPTH - 1));

    // index register: clear wins, never steps past the last element
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (inc && !last) begin
            idx <= idx + 1'b1;
        end
    end

endmodule

// File: rtl/array_xfer_ctrl.sv
// Whole-array copy/fill sequencer, one element write per cycle.
// Copy writes trail their reads by one cycle; abortable at any busy cycle.
module array_xfer_ctrl #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 2,
    parameter int IDX_W = $clog2(DEPTH > 1 ? DEPTH : 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] fill_val,
    input  logic             abort,
    output logic             src_rd_en,
    output logic [IDX_W-1:0] src_rd_idx,
    input  logic [WIDTH-1:0] src_rd_data,
    output logic             dst_wr_en,
    output logic [IDX_W-1:0] dst_wr_idx,
    output logic [WIDTH-1:0] dst_wr_data,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    import array_xfer_pkg::*;

    xfer_state_t      state;
    logic             copy_wr;
    logic [WIDTH-1:0] data_q;
    logic [IDX_W-1:0] cnt_idx;
    logic             cnt_last;
    logic             cnt_clear;
    logic             cnt_inc;
    logic             active;
    logic             stop;

    assign active    = (state == READ) || (state == FILL);
    assign stop      = abort && (active || (state == DRAIN));
    assign cnt_clear = !active || abort;
    assign cnt_inc   = active && !abort;

    assign src_rd_idx = cnt_idx;

    // Source data arrives from the array's registered read port, so a
    // copy write forwards it directly; a fill write uses the latched value.
    assign dst_wr_data = copy_wr ? src_rd_data : data_q;

    xfer_idx_cnt #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_idx (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .idx   (cnt_idx),
        .last  (cnt_last)
    );

    // sequencer state and registered strobes/pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            src_rd_en  <= 1'b0;
            dst_wr_en  <= 1'b0;
            dst_wr_idx <= '0;
            data_q     <= '0;
            copy_wr    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            if (stop) begin
                state      <= IDLE;
                src_rd_en  <= 1'b0;
                dst_wr_en  <= 1'b0;
                dst_wr_idx <= '0;
                data_q     <= '0;
                copy_wr    <= 1'b0;
                busy       <= 1'b0;
                aborted    <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            busy <= 1'b1;
                            unique case (mode)
                                MODE_COPY: begin
                                    state     <= READ;
                                    src_rd_en <= 1'b1;
                                end
                                MODE_FILL: begin
                                    state      <= FILL;
                                    dst_wr_en  <= 1'b1;
                                    dst_wr_idx <= '0;
                                    data_q     <= fill_val;
                                end
                            endcase
                        end
                    end
                    READ: begin
                        dst_wr_en  <= 1'b1;
                        copy_wr    <= 1'b1;
                        dst_wr_idx <= cnt_idx;
                        if (cnt_last) begin
                            state     <= DRAIN;
                            src_rd_en <= 1'b0;
                        end
                    end
                    DRAIN: begin
                        state      <= DONE;
                        dst_wr_en  <= 1'b0;
                        dst_wr_idx <= '0;
                        copy_wr    <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end
                    FILL: begin
                        if (cnt_last) begin
                            state      <= DONE;
                            dst_wr_en  <= 1'b0;
                            dst_wr_idx <= '0;
                            data_q     <= '0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            dst_wr_idx <= cnt_idx + 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_array_xfer_ctrl.sv
// Scoreboard bench for array_xfer_ctrl (DEPTH=3, WIDTH=2).
// Expected reads/writes/pulses are queued with their cycle stamps.
module tb_array_xfer_ctrl;

    localparam int DEPTH = 3;
    localparam int WIDTH = 2;
    localparam int IDX_W = 2;

    typedef struct {
        int cyc;
        int idx;
        int data;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             mode = 1'b0;
    logic [WIDTH-1:0] fill_val = '0;
    logic             abort = 1'b0;
    logic             src_rd_en;
    logic [IDX_W-1:0] src_rd_idx;
    logic [WIDTH-1:0] src_rd_data;
    logic             dst_wr_en;
    logic [IDX_W-1:0] dst_wr_idx;
    logic [WIDTH-1:0] dst_wr_data;
    logic             busy;
    logic             done;
    logic             aborted;

    logic [WIDTH-1:0] src_mem [DEPTH];

    ev_t wr_q[$];
    ev_t rd_q[$];
    ev_t pulse_q[$];

    int cyc = 0;
    int busy_lo = 1;
    int busy_hi = 0;
    int errors = 0;
    int checks = 0;

    array_xfer_ctrl #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mode        (mode),
        .fill_val    (fill_val),
        .abort       (abort),
        .src_rd_en   (src_rd_en),
        .src_rd_idx  (src_rd_idx),
        .src_rd_data (src_rd_data),
        .dst_wr_en   (dst_wr_en),
        .dst_wr_idx  (dst_wr_idx),
        .dst_wr_data (dst_wr_data),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // source array with a registered read port
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) src_rd_data <= '0;
        else if (src_rd_en) src_rd_data <= src_mem[src_rd_idx];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got strobe expected none (cycle %0d)", name, cyc);
    endtask

    // monitor: pops expectations whenever the DUT shows a strobe or pulse
    always @(negedge clk) begin
        ev_t e;
        if (rst_n) begin
            if (dst_wr_en) begin
                if (wr_q.size() == 0) unexpected("wr");
                else begin
                    e = wr_q.pop_front();
                    chk("wr_cyc", cyc, e.cyc);
                    chk("wr_idx", int'(dst_wr_idx), e.idx);
                    chk("wr_data", int'(dst_wr_data), e.data);
                end
            end
            if (src_rd_en) begin
                if (rd_q.size() == 0) unexpected("rd");
                else begin
                    e = rd_q.pop_front();
                    chk("rd_cyc", cyc, e.cyc);
                    chk("rd_idx", int'(src_rd_idx), e.idx);
                end
            end
            if (done || aborted) begin
                if (pulse_q.size() == 0) unexpected("pulse");
                else begin
                    e = pulse_q.pop_front();
                    chk("pulse_cyc", cyc, e.cyc);
                    chk("pulse_done", int'(done), e.idx == 0 ? 1 : 0);
                    chk("pulse_abort", int'(aborted), e.idx == 1 ? 1 : 0);
                end
            end
            chk("busy", int'(busy), (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_check(input string tag);
        chk({tag, "_wr_left"}, wr_q.size(), 0);
        chk({tag, "_rd_left"}, rd_q.size(), 0);
        chk({tag, "_pulse_left"}, pulse_q.size(), 0);
        wr_q.delete();
        rd_q.delete();
        pulse_q.delete();
    endtask

    // One operation started in the current cycle c0. abort_k / stray_k
    // give the cycle offset of an abort / ignored start (0 = none).
    task automatic do_op(input logic m, input logic [WIDTH-1:0] fv,
                         input int abort_k, input int stray_k,
                         input logic stray_mode);
        int c0;
        int op_len;
        int ab;
        int end_c;
        ev_t e;
        c0 = cyc;
        op_len = m ? DEPTH + 1 : DEPTH + 2;
        ab = (abort_k >= 1 && abort_k < op_len) ? abort_k : 0;
        end_c = (ab != 0) ? ab : op_len - 1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m) begin
                if (1 + i <= end_c) begin
                    e.cyc = c0 + 1 + i; e.idx = i; e.data = int'(fv);
                    wr_q.push_back(e);
                end
            end else begin
                if (1 + i <= end_c) begin
                    e.cyc = c0 + 1 + i; e.idx = i; e.data = 0;
                    rd_q.push_back(e);
                end
                if (2 + i <= end_c) begin
                    e.cyc = c0 + 2 + i; e.idx = i; e.data = int'(src_mem[i]);
                    wr_q.push_back(e);
                end
            end
        end
        e.cyc = (ab != 0) ? c0 + ab + 1 : c0 + op_len;
        e.idx = (ab != 0) ? 1 : 0;
        e.data = 0;
        pulse_q.push_back(e);
        busy_lo = c0 + 1;
        busy_hi = c0 + end_c;
        start = 1'b1;
        mode = m;
        fill_val = fv;
        for (int t = 1; t <= DEPTH + 5; t++) begin
            tick();
            start = 1'b0;
            abort = (t == abort_k);
            mode = 1'($urandom_range(0, 1));
            fill_val = WIDTH'($urandom_range(0, 3));
            if (t == stray_k) begin
                start = 1'b1;
                mode = stray_mode;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        drain_check(m ? "fill" : "copy");
    endtask

    initial begin
        int ak;
        int sk;
        int len;
        logic rm;
        for (int i = 0; i < DEPTH; i++) src_mem[i] = '0;
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_aborted", int'(aborted), 0);
        chk("rst_rd_en", int'(src_rd_en), 0);
        chk("rst_wr_en", int'(dst_wr_en), 0);
        chk("rst_wr_idx", int'(dst_wr_idx), 0);
        chk("rst_wr_data", int'(dst_wr_data), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // directed: copy {3,1,2}
        src_mem[0] = 2'd3; src_mem[1] = 2'd1; src_mem[2] = 2'd2;
        do_op(1'b0, 2'd0, 0, 0, 1'b0);
        // directed: fill 2'b10
        do_op(1'b1, 2'b10, 0, 0, 1'b0);
        // directed: abort during copy at c2
        do_op(1'b0, 2'd0, 2, 0, 1'b0);
        // directed: start with mode=1 at c2 during copy is ignored
        do_op(1'b0, 2'd0, 0, 2, 1'b1);
        // directed: abort during drain and during last fill cycle
        do_op(1'b0, 2'd0, 4, 0, 1'b0);
        do_op(1'b1, 2'd1, 3, 0, 1'b0);

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        mode = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int t = 0; t < 6; t++) tick();
        drain_check("idle_abort");

        // reset in the middle of a fill
        begin
            ev_t e;
            int c0;
            c0 = cyc;
            e.cyc = c0 + 1; e.idx = 0; e.data = 1;
            wr_q.push_back(e);
            busy_lo = c0 + 1;
            busy_hi = c0 + 1;
            start = 1'b1;
            mode = 1'b1;
            fill_val = 2'd1;
            tick();
            start = 1'b0;
            tick();
            rst_n = 1'b0;
            #1;
            chk("midrst_wr_en", int'(dst_wr_en), 0);
            chk("midrst_busy", int'(busy), 0);
            chk("midrst_rd_en", int'(src_rd_en), 0);
            chk("midrst_done", int'(done), 0);
            chk("midrst_aborted", int'(aborted), 0);
            chk("midrst_wr_data", int'(dst_wr_data), 0);
            tick();
            tick();
            rst_n = 1'b1;
            tick();
            tick();
            drain_check("midrst");
        end
        do_op(1'b1, 2'd3, 0, 0, 1'b0);

        // randomized operations
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < DEPTH; i++) src_mem[i] = WIDTH'($urandom_range(0, 3));
            rm = 1'($urandom_range(0, 1));
            len = rm ? DEPTH + 1 : DEPTH + 2;
            ak = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len) : 0;
            sk = ($urandom_range(0, 1) == 0) ? $urandom_range(1, len) : 0;
            if (ak != 0 && sk > ak) sk = ak;
            do_op(rm, WIDTH'($urandom_range(0, 3)), ak, sk,
                  1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
